// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequencer slice.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Maximal-length feedback masks; bit i set = state[i] feeds the XOR.
  localparam logic [3:0]  TAPS_W4  = 4'b1100;
  localparam logic [7:0]  TAPS_W8  = 8'b1011_1000;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  // Default tap mask for a given width, zero-extended to 16 bits.
  function automatic logic [15:0] default_taps(input int unsigned width);
    case (width)
      32'd8:   return 16'(TAPS_W8);
      32'd16:  return TAPS_W16;
      default: return 16'(TAPS_W4);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with reset-to-one, parallel load and single step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  // Load has priority over step; otherwise the state holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WIDTH'(1);
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven burst sequencer streaming LFSR states on a valid/ready port.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic             cmd_keep,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             err_seed
);

  state_t           state, state_n;
  logic [CNT_W-1:0] remaining, rem_n;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] len_q;
  logic             keep_q;
  logic             err_n;
  logic             capture;
  logic             core_load;
  logic [WIDTH-1:0] core_load_val;
  logic             core_step;
  logic             xfer;

  assign xfer = out_valid & out_ready;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (core_load_val),
    .step     (core_step),
    .state    (out_data)
  );

  // Next-state, counter, sticky error and core control.
  always_comb begin
    state_n       = state;
    rem_n         = remaining;
    err_n         = err_seed;
    capture       = 1'b0;
    core_load     = 1'b0;
    core_load_val = seed_q;
    core_step     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (!cmd_keep && (cmd_seed == '0)) begin
            err_n = 1'b1;
          end else begin
            err_n   = 1'b0;
            capture = 1'b1;
            if (cmd_len == '0) begin
              // Zero-length burst skips LOAD, so the seed goes in now.
              core_load     = ~cmd_keep;
              core_load_val = cmd_seed;
              state_n       = DONE;
            end else begin
              state_n = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          core_load = ~keep_q;
          rem_n     = len_q;
          state_n   = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          core_step = 1'b1;
          if (remaining != '0) begin
            rem_n = remaining - CNT_W'(1);
          end
          if (remaining == CNT_W'(1)) begin
            state_n = DONE;
          end
        end
        if (abort) begin
          state_n = IDLE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      cmd_ready <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_seed  <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      cmd_ready <= (state_n == IDLE);
      out_valid <= (state_n == RUN);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      err_seed  <= err_n;
    end
  end

  // Command capture at accept; inputs are don't-care afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q <= '0;
      len_q  <= '0;
      keep_q <= 1'b0;
    end else if (capture) begin
      seed_q <= cmd_seed;
      len_q  <= cmd_len;
      keep_q <= cmd_keep;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: per-cycle vector table plus corner sequences.
module tb_lfsr_seq_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_seed;
  logic             cmd_keep;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic             err_seed;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             cv;
    logic [WIDTH-1:0] seed;
    logic             keep;
    logic [CNT_W-1:0] len;
    logic             rdy;
    logic             ab;
    logic             e_valid;
    logic [WIDTH-1:0] e_data;
    logic             e_done;
    logic             e_cready;
    logic             e_busy;
    logic             e_err;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH-1:0] beats[$];

  lfsr_seq_ctrl #(
    .WIDTH (WIDTH),
    .TAPS  (4'b1100),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_seed  (cmd_seed),
    .cmd_keep  (cmd_keep),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err_seed  (err_seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cv, input logic [3:0] seed, input logic keep,
                              input logic [7:0] len, input logic rdy, input logic ab,
                              input logic ev, input logic [3:0] ed, input logic edn,
                              input logic ecr, input logic eb, input logic ee);
    vec_t v;
    v.cv = cv; v.seed = seed; v.keep = keep; v.len = len; v.rdy = rdy; v.ab = ab;
    v.e_valid = ev; v.e_data = ed; v.e_done = edn; v.e_cready = ecr; v.e_busy = eb; v.e_err = ee;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for one edge (caller ensures the controller is idle).
  task automatic do_cmd(input logic [3:0] seed, input logic keep, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_seed  = seed;
    cmd_keep  = keep;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_seed  = 4'h0;
    cmd_keep  = 1'b0;
    cmd_len   = 8'd0;
  endtask

  // Record transferred beats until done, bounded; then step back to idle.
  task automatic collect(input int budget, output bit got_done);
    got_done = 1'b0;
    beats.delete();
    out_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (out_valid && out_ready) beats.push_back(out_data);
      tick();
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    tick();
  endtask

  initial begin
    bit          got;
    logic [15:0] seen;
    bit          saw_done;

    rst = 1'b1; cmd_valid = 1'b0; cmd_seed = 4'h0; cmd_keep = 1'b0;
    cmd_len = 8'd0; abort = 1'b0; out_ready = 1'b0;

    // Reset values.
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err_seed",  32'(err_seed),  32'd0);
    rst = 1'b0;
    tick();

    // Burst seed=0001 len=7, out_ready high.
    vecs.push_back(mk(1, 4'h1, 0, 8'd7, 1, 0,  0, 4'h1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h4, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h9, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h6, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'hD, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  0, 4'hA, 1, 0, 1, 0));
    // Command offered during DONE is held off, then accepted in IDLE.
    vecs.push_back(mk(1, 4'h1, 0, 8'd3, 0, 0,  0, 4'hA, 0, 1, 0, 0));
    // Backpressure burst seed=0001 len=3, out_ready toggling.
    vecs.push_back(mk(1, 4'h1, 0, 8'd3, 0, 0,  0, 4'hA, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0,  1, 4'h1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0,  1, 4'h2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  1, 4'h4, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0,  1, 4'h4, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0,  0, 4'h9, 1, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0,  0, 4'h9, 0, 1, 0, 0));
    // Abort in IDLE has no effect.
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 1,  0, 4'h9, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      cmd_valid = vecs[i].cv;  cmd_seed = vecs[i].seed; cmd_keep = vecs[i].keep;
      cmd_len   = vecs[i].len; out_ready = vecs[i].rdy;  abort = vecs[i].ab;
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_out_data",  i), 32'(out_data),  32'(vecs[i].e_data));
      check($sformatf("vec%0d_done",      i), 32'(done),      32'(vecs[i].e_done));
      check($sformatf("vec%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_cready));
      check($sformatf("vec%0d_busy",      i), 32'(busy),      32'(vecs[i].e_busy));
      check($sformatf("vec%0d_err_seed",  i), 32'(err_seed),  32'(vecs[i].e_err));
    end
    cmd_valid = 1'b0; abort = 1'b0;

    // Full period: 15 distinct nonzero states starting at the seed.
    do_cmd(4'h1, 1'b0, 8'd15);
    collect(40, got);
    check("period_done", 32'(got), 32'd1);
    check("period_count", 32'(beats.size()), 32'd15);
    seen = 16'h0;
    foreach (beats[i]) seen[beats[i]] = 1'b1;
    check("period_distinct", 32'(seen), 32'hFFFE);
    if (beats.size() > 0) check("period_first", 32'(beats[0]), 32'h1);
    check("period_cmd_ready", 32'(cmd_ready), 32'd1);

    // keep=1 continues from the wrapped state.
    do_cmd(4'hF, 1'b1, 8'd1);
    collect(10, got);
    check("wrap_count", 32'(beats.size()), 32'd1);
    if (beats.size() > 0) check("wrap_beat", 32'(beats[0]), 32'h1);

    // Zero seed rejected: sticky error, no burst, state untouched (now 0010).
    do_cmd(4'h0, 1'b0, 8'd5);
    check("zseed_err", 32'(err_seed), 32'd1);
    check("zseed_cmd_ready", 32'(cmd_ready), 32'd1);
    check("zseed_busy", 32'(busy), 32'd0);
    check("zseed_data", 32'(out_data), 32'h2);
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || out_valid) saw_done = 1'b1;
    end
    check("zseed_no_burst", 32'(saw_done), 32'd0);
    check("zseed_err_sticky", 32'(err_seed), 32'd1);

    do_cmd(4'h8, 1'b0, 8'd1);
    check("err_clear", 32'(err_seed), 32'd0);
    collect(10, got);
    check("after_err_count", 32'(beats.size()), 32'd1);
    if (beats.size() > 0) check("after_err_beat", 32'(beats[0]), 32'h8);

    // Zero-length burst: done one cycle after accept, seed still loaded.
    do_cmd(4'h5, 1'b0, 8'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_valid", 32'(out_valid), 32'd0);
    check("len0_data", 32'(out_data), 32'h5);
    tick();
    check("len0_done_clear", 32'(done), 32'd0);
    check("len0_cmd_ready", 32'(cmd_ready), 32'd1);
    do_cmd(4'h0, 1'b1, 8'd1);
    collect(10, got);
    check("len0_keep_count", 32'(beats.size()), 32'd1);
    if (beats.size() > 0) check("len0_keep_beat", 32'(beats[0]), 32'h5);

    // Abort coincident with the second transfer of a len=10 burst.
    out_ready = 1'b1;
    do_cmd(4'h1, 1'b0, 8'd10);
    tick();
    check("abort_beat1", 32'(out_data), 32'h1);
    tick();
    check("abort_beat2", 32'(out_data), 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", 32'(out_data), 32'h4);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_data_hold", 32'(out_data), 32'h4);

    // Async reset mid-burst clears outputs without a clock edge.
    do_cmd(4'h7, 1'b0, 8'd10);
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'h1);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_idle_data", 32'(out_data), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
